// File: rtl/hcsr04_responder.sv
// HC-SR04 ultrasonic sensor emulator: answers a trig pulse with an echo pulse
// whose width encodes a programmed distance, following the sensor's timing.
module hcsr04_responder #(
  parameter int TRIG_MIN_CYC  = 500,
  parameter int BURST_DLY_CYC = 10000,
  parameter int CYC_PER_MM    = 290,
  parameter int MAX_MM        = 4000,
  parameter int TIMEOUT_CYC   = 1900000,
  parameter int HOLDOFF_CYC   = 50000
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        trig,
  input  logic [15:0] distance_mm,
  output logic        echo,
  output logic        busy,
  output logic        short_trig,
  output logic [7:0]  meas_count
);

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

  localparam logic [23:0] TRIG_MIN    = 24'(TRIG_MIN_CYC);
  localparam logic [23:0] BURST_LAST  = 24'(BURST_DLY_CYC - 1);
  localparam logic [23:0] PER_MM      = 24'(CYC_PER_MM);
  localparam logic [23:0] TIMEOUT     = 24'(TIMEOUT_CYC);
  localparam logic [23:0] HOLDOFF_LEN = 24'(HOLDOFF_CYC);
  localparam logic [15:0] MAX_D       = 16'(MAX_MM);

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [23:0] width, width_n, width_calc;
  logic [15:0] d_eff;
  logic [7:0]  meas_n;
  logic        short_n, echo_n, busy_n;
  logic        trig_meta, trig_s, low_seen;
  logic [1:0]  prime;

  // low_seen only arms once the synchronizer holds real samples, so a trig
  // held high through reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      low_seen  <= 1'b0;
      prime     <= 2'd0;
    end else begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
      low_seen  <= (prime == 2'd2) ? !trig_s : 1'b0;
      if (prime != 2'd2) begin
        prime <= prime + 2'd1;
      end
    end
  end

  always_comb begin
    d_eff = (distance_mm == 16'd0) ? 16'd1 : distance_mm;
    if (distance_mm > MAX_D) begin
      width_calc = TIMEOUT;
    end else begin
      width_calc = 24'(d_eff) * PER_MM;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    width_n = width;
    meas_n  = meas_count;
    short_n = 1'b0;
    case (state)
      IDLE: begin
        if (trig_s && low_seen) begin
          state_n = TRIG_HI;
          cnt_n   = 24'd1;
        end else begin
          cnt_n   = 24'd0;
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (cnt < TRIG_MIN) begin
            cnt_n = cnt + 24'd1;
          end else begin
            cnt_n = cnt;
          end
        end else if (cnt >= TRIG_MIN) begin
          state_n = BURST;
          cnt_n   = 24'd1;
          width_n = width_calc;
          meas_n  = meas_count + 8'd1;
        end else begin
          state_n = IDLE;
          cnt_n   = 24'd0;
          short_n = 1'b1;
        end
      end
      // cnt starts at 1 so echo rises exactly BURST_DLY_CYC cycles after the fall
      BURST: begin
        if (cnt >= BURST_LAST) begin
          state_n = ECHO;
          cnt_n   = 24'd1;
        end else begin
          cnt_n   = cnt + 24'd1;
        end
      end
      ECHO: begin
        if (cnt >= width) begin
          state_n = HOLDOFF;
          cnt_n   = 24'd1;
        end else begin
          cnt_n   = cnt + 24'd1;
        end
      end
      HOLDOFF: begin
        if (cnt >= HOLDOFF_LEN) begin
          state_n = IDLE;
          cnt_n   = 24'd0;
        end else begin
          cnt_n   = cnt + 24'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 24'd0;
      end
    endcase
    echo_n = (state_n == ECHO);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 24'd0;
      width      <= 24'd0;
      meas_count <= 8'd0;
      short_trig <= 1'b0;
      echo       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      width      <= width_n;
      meas_count <= meas_n;
      short_trig <= short_n;
      echo       <= echo_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_hcsr04_responder.sv
// Directed bench for hcsr04_responder using shrunken timing parameters:
// TRIG_MIN=5, BURST=20, CYC_PER_MM=3, MAX_MM=40, TIMEOUT=200, HOLDOFF=30.
module tb_hcsr04_responder;

  logic        clk_50M = 1'b0;
  logic        reset;
  logic        trig;
  logic [15:0] distance_mm;
  logic        echo, busy, short_trig;
  logic [7:0]  meas_count;
  int          total = 0;
  int          bad = 0;
  int          n;
  logic        seen;

  hcsr04_responder #(
    .TRIG_MIN_CYC(5), .BURST_DLY_CYC(20), .CYC_PER_MM(3),
    .MAX_MM(40), .TIMEOUT_CYC(200), .HOLDOFF_CYC(30)
  ) dut (
    .clk_50M(clk_50M), .reset(reset), .trig(trig), .distance_mm(distance_mm),
    .echo(echo), .busy(busy), .short_trig(short_trig), .meas_count(meas_count)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic tick(input int k);
    repeat (k) @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int k);
    trig = 1'b1;
    tick(k);
    trig = 1'b0;
  endtask

  // cycles until echo reaches v; -1 when the bound runs out
  task automatic wait_echo(input logic v, input int bound, output int cyc);
    cyc = 0;
    while (echo !== v && cyc < bound) begin
      tick(1);
      cyc++;
    end
    if (echo !== v) cyc = -1;
  endtask

  task automatic wait_busy_low(input int bound, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < bound) begin
      tick(1);
      cyc++;
    end
    if (busy !== 1'b0) cyc = -1;
  endtask

  task automatic wait_short(input int bound, output int cyc);
    cyc = 0;
    while (short_trig !== 1'b1 && cyc < bound) begin
      tick(1);
      cyc++;
    end
    if (short_trig !== 1'b1) cyc = -1;
  endtask

  initial begin
    reset = 1'b1;
    trig = 1'b0;
    distance_mm = 16'd10;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_echo", int'(echo), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_short", int'(short_trig), 0);
    chk("reset_meas", int'(meas_count), 0);

    // d=10 -> width 30, rise 22 cycles after trig falls on the pin
    pulse(6);
    chk("busy_after_trig", int'(busy), 1);
    wait_echo(1'b1, 500, n);
    chk("basic_rise", n, 22);
    chk("basic_meas", int'(meas_count), 1);
    wait_echo(1'b0, 500, n);
    chk("basic_width", n, 30);
    chk("holdoff_busy", int'(busy), 1);
    wait_busy_low(500, n);
    chk("basic_holdoff", n, 30);

    // one cycle short of the minimum is rejected
    tick(3);
    pulse(4);
    wait_short(50, n);
    chk("short_latency", n, 3);
    tick(1);
    chk("short_one_cycle", int'(short_trig), 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (echo === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("short_no_echo", int'(seen), 0);
    chk("short_meas", int'(meas_count), 1);

    // exact minimum accepted; distance change during BURST ignored
    pulse(5);
    tick(5);
    distance_mm = 16'd30;
    wait_echo(1'b1, 500, n);
    chk("min_trig_rise", n, 17);
    chk("min_trig_meas", int'(meas_count), 2);
    pulse(6);
    wait_echo(1'b0, 500, n);
    chk("latched_width", n, 24);
    pulse(6);
    wait_busy_low(500, n);
    chk("ignored_holdoff", n, 24);
    chk("ignored_meas", int'(meas_count), 2);

    // out of range -> timeout width; new trigger after holdoff
    distance_mm = 16'd41;
    tick(3);
    pulse(6);
    wait_echo(1'b1, 500, n);
    chk("after_holdoff_rise", n, 22);
    chk("after_holdoff_meas", int'(meas_count), 3);
    wait_echo(1'b0, 500, n);
    chk("timeout_width", n, 200);
    wait_busy_low(500, n);

    distance_mm = 16'd40;
    pulse(6);
    wait_echo(1'b1, 500, n);
    wait_echo(1'b0, 500, n);
    chk("max_width", n, 120);
    wait_busy_low(500, n);

    distance_mm = 16'd0;
    pulse(6);
    wait_echo(1'b1, 500, n);
    wait_echo(1'b0, 500, n);
    chk("zero_width", n, 3);
    wait_busy_low(500, n);
    chk("zero_meas", int'(meas_count), 5);

    // reset mid-echo with trig held high across release
    distance_mm = 16'd10;
    pulse(6);
    wait_echo(1'b1, 500, n);
    tick(5);
    reset = 1'b1;
    trig = 1'b1;
    tick(1);
    chk("midreset_echo", int'(echo), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_meas", int'(meas_count), 0);
    tick(2);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy === 1'b1 || short_trig === 1'b1) seen = 1'b1;
    end
    chk("held_trig_ignored", int'(seen), 0);
    trig = 1'b0;
    tick(5);
    pulse(6);
    wait_echo(1'b1, 500, n);
    chk("rearm_rise", n, 22);
    chk("rearm_meas", int'(meas_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
